// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions used by both the transmit and receive
//            halves: the frame-level state enumeration and default frame
//            geometry constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default frame geometry: 8 payload bits, 8 oversampling ticks per bit.
    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 8;

    // Encoded width of the frame state.
    localparam int STATE_W = 3;

    // Frame state naming shared with uart_tx.
    typedef enum logic [STATE_W-1:0] {
        UART_IDLE    = 3'd0,
        UART_START   = 3'd1,
        UART_DATA    = 3'd2,
        UART_STOP    = 3'd3,
        UART_RECOVER = 3'd4
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Bundles the receiver's baud strobe, serial line and recovered
//            byte/status signals.
// Signals  : tick_8x   - one-clk enable strobe at OVERSAMPLE x baud
//            rx_serial - asynchronous serial line, idle high
//            rx_data   - last correctly framed byte
//            rx_valid  - one-clk pulse when rx_data updates
//            frame_err - one-clk pulse on a low stop bit
//            busy      - receiver is inside a frame
// Modports : master - line/strobe source and consumer of received bytes
//            slave  - the receiver itself
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
);
    logic                 tick_8x;
    logic                 rx_serial;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output tick_8x,
        output rx_serial,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  tick_8x,
        input  rx_serial,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Generic single-bit two-flop synchronizer for bringing an
//            asynchronous input into the clk domain. Both flops reset to
//            RESET_VAL so the output starts at the input's idle level.
// Ports    : clk      - destination clock
//            rst      - synchronous active-high reset
//            i_async  - asynchronous input
//            o_sync   - synchronized output (2 clk latency)
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with OVERSAMPLE-times oversampling. Each bit
//            is sampled near its centre; good frames update rx_data with a
//            one-clk rx_valid pulse, a low stop bit gives a one-clk
//            frame_err pulse and leaves rx_data untouched.
// Ports    : clk - system clock (rising edge)
//            rst - synchronous active-high reset
//            bus - uart_rx_if slave modport (tick_8x, rx_serial in;
//                  rx_data, rx_valid, frame_err, busy out)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    uart_rx_if.slave   bus
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS) + 1;

    localparam logic [STATE_W-1:0] c_IDLE    = UART_IDLE;
    localparam logic [STATE_W-1:0] c_START   = UART_START;
    localparam logic [STATE_W-1:0] c_DATA    = UART_DATA;
    localparam logic [STATE_W-1:0] c_STOP    = UART_STOP;
    localparam logic [STATE_W-1:0] c_RECOVER = UART_RECOVER;

    localparam logic [TICK_W-1:0] c_HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] c_LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] c_TICK_ONE  = TICK_W'(1);
    localparam logic [BIT_W-1:0]  c_LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  c_BIT_ONE   = BIT_W'(1);

    logic                 w_rx_s;
    logic [STATE_W-1:0]   r_state;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_err;

    // Line idles high, so the synchronizer resets to 1 to avoid a spurious
    // start detection straight out of reset.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.rx_serial),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Status pulses last exactly one clk regardless of tick rate.
            r_valid <= 1'b0;
            r_err   <= 1'b0;

            if (bus.tick_8x) begin
                case (r_state)
                    c_IDLE: begin
                        if (!w_rx_s) begin
                            r_state    <= c_START;
                            r_tick_cnt <= '0;
                        end
                    end

                    // Re-check the line half a bit after the falling edge so
                    // glitches shorter than that are rejected, and so later
                    // samples land at bit centres.
                    c_START: begin
                        if (r_tick_cnt == c_HALF_TICK) begin
                            if (!w_rx_s) begin
                                r_state    <= c_DATA;
                                r_tick_cnt <= '0;
                                r_bit_cnt  <= '0;
                            end else begin
                                r_state <= c_IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
                        end
                    end

                    // Right shift with the new bit entering at the MSB leaves
                    // the first-received (LSB) bit at position 0.
                    c_DATA: begin
                        if (r_tick_cnt == c_LAST_TICK) begin
                            r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= r_bit_cnt + c_BIT_ONE;
                            if (r_bit_cnt == c_LAST_BIT) begin
                                r_state <= c_STOP;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
                        end
                    end

                    // Leaving at mid-stop-bit gives half a bit of margin for
                    // a following start edge with no idle gap.
                    c_STOP: begin
                        if (r_tick_cnt == c_LAST_TICK) begin
                            r_tick_cnt <= '0;
                            if (w_rx_s) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                                r_state <= c_IDLE;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= c_RECOVER;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
                        end
                    end

                    // A held-low line (break) must not be read as a stream
                    // of start bits; wait for the line to return high.
                    c_RECOVER: begin
                        if (w_rx_s) begin
                            r_state <= c_IDLE;
                        end
                    end

                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data   = r_data;
    assign bus.rx_valid  = r_valid;
    assign bus.frame_err = r_err;
    assign bus.busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. A behavioural line driver
//            builds 8N1 frames bit by bit; each frame's expected outcome
//            (good byte or framing error) is queued when it is sent and a
//            separate monitor compares it against every DUT pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DB = 8;
    localparam int OS = 8;

    logic clk = 1'b0;
    logic rst;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        logic [DB-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_checks   = 0;
    int            n_pass     = 0;
    logic [DB-1:0] model_last = '0;
    int            tick_period = 5;
    int            tick_phase  = 0;
    int            tick_num    = 0;
    logic          prev_valid  = 1'b0;
    logic          prev_err    = 1'b0;
    bit            gap_en      = 1'b0;
    int            low_run     = 0;
    int            max_gap     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, req, $time);
    endtask

    // Baud strobe: one clk high every tick_period clks, or always high.
    initial begin
        bus.tick_8x = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_period <= 1) begin
                bus.tick_8x = 1'b1;
            end else begin
                tick_phase  = (tick_phase + 1) % tick_period;
                bus.tick_8x = (tick_phase == 0);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (bus.tick_8x === 1'b1) tick_num++;
        end
    end

    // Busy-low run lengths, recorded when busy rises again.
    initial begin
        forever begin
            @(negedge clk);
            if (gap_en) begin
                if (!bus.busy) low_run++;
                else begin
                    if (low_run > max_gap) max_gap = low_run;
                    low_run = 0;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && (bus.rx_valid === 1'b1 || bus.frame_err === 1'b1)) begin
                check("pulse_exclusive", 32'(bus.rx_valid & bus.frame_err), 32'd0);
                check("pulse_width", 32'((bus.rx_valid & prev_valid) | (bus.frame_err & prev_err)), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, bus.rx_valid, bus.frame_err}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_err) begin
                        check("frame_err_pulse", {30'd0, bus.rx_valid, bus.frame_err}, 32'd1);
                        check("rx_data_hold", 32'(bus.rx_data), 32'(model_last));
                    end else begin
                        check("rx_valid_pulse", {30'd0, bus.rx_valid, bus.frame_err}, 32'd2);
                        check("rx_data", 32'(bus.rx_data), 32'(mon_e.data));
                        check("busy_falls_with_valid", 32'(bus.busy), 32'd0);
                        model_last = mon_e.data;
                    end
                end
            end
            prev_valid = bus.rx_valid;
            prev_err   = bus.frame_err;
        end
    end

    task automatic wait_ticks(input int n);
        int tgt;
        tgt = tick_num + n;
        while (tick_num < tgt) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.rx_serial = b;
        wait_ticks(OS);
    endtask

    task automatic idle_bits(input int n);
        bus.rx_serial = 1'b1;
        wait_ticks(n * OS);
    endtask

    // Expected outcome of a frame: a good stop bit delivers the byte,
    // a low stop bit gives a framing error.
    task automatic send_frame(input logic [DB-1:0] data, input logic stop);
        exp_t e;
        e.is_err = !stop;
        e.data   = data;
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(data[i]);
        send_bit(stop);
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
        check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
        check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
        n_checks++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        logic [7:0] lb [4];
        int         busy_a;
        int         busy_b;
        logic [7:0] rb;
        logic       ok;
        int         gap;

        lb[0] = 8'h55; lb[1] = 8'hAA; lb[2] = 8'h41; lb[3] = 8'hFF;

        rst           = 1'b1;
        bus.rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle_bits(2);

        // Loopback-style bytes with a one-bit idle gap.
        for (int i = 0; i < 4; i++) begin
            send_frame(lb[i], 1'b1);
            idle_bits(1);
        end
        idle_bits(1);
        check_drained("loopback_drain");

        // Back-to-back frames with no idle between them.
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                wait_ticks(2);
                low_run = 0;
                max_gap = 0;
                gap_en  = 1'b1;
            end
        join
        gap_en = 1'b0;
        idle_bits(1);
        check_drained("b2b_drain");
        check("b2b_gap_bounded", 32'(max_gap > 0 && max_gap <= (OS / 2 + 2) * tick_period), 32'd1);

        // False start: 2 ticks low.
        busy_a = 0;
        busy_b = 0;
        bus.rx_serial = 1'b0;
        for (int t = 0; t < 2 * tick_period; t++) begin
            @(negedge clk);
            if (bus.busy) busy_a++;
        end
        bus.rx_serial = 1'b1;
        for (int t = 0; t < 8 * tick_period; t++) begin
            @(negedge clk);
            if (bus.busy) busy_b++;
        end
        check("false_start_busy_window", 32'((busy_a + busy_b) > 0 && (busy_a + busy_b) <= 4 * tick_period), 32'd1);
        check("false_start_idle_after", 32'(bus.busy), 32'd0);
        idle_bits(1);
        send_frame(8'h41, 1'b1);
        idle_bits(1);
        check_drained("false_start_drain");

        // Framing error followed by a 30-bit break.
        send_frame(8'h3C, 1'b0);
        wait_ticks(30 * OS);
        idle_bits(2);
        check_drained("frame_err_drain");
        send_frame(8'hA5, 1'b1);
        idle_bits(1);
        check_drained("after_break_drain");

        // Reset in the middle of data bit 4 of 0x96.
        rb = 8'h96;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(rb[i]);
        bus.rx_serial = rb[4];
        wait_ticks(OS / 2);
        rst = 1'b1;
        @(negedge clk);
        model_last = '0;
        check_reset_outputs("midframe_reset");
        rst = 1'b0;
        idle_bits(3);
        send_frame(8'h69, 1'b1);
        idle_bits(1);
        check_drained("after_reset_drain");

        // Randomized frames at two tick rates, including continuous ticks.
        for (int p = 0; p < 2; p++) begin
            tick_period = (p == 0) ? 5 : 1;
            idle_bits(2);
            for (int n = 0; n < 12; n++) begin
                rb = 8'($urandom);
                ok = ($urandom_range(0, 4) != 0);
                send_frame(rb, ok);
                gap = ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
                if (gap > 0) idle_bits(gap);
            end
            idle_bits(2);
            check_drained("random_drain");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
